// File: rtl/ladybird_config_pkg.sv
// Shared ladybird bus configuration: word width and copy-engine state encoding.
package ladybird_config;

  localparam int unsigned XLEN       = 32;
  localparam int unsigned WORD_BYTES = XLEN / 8;

  typedef enum logic [2:0] {
    StIdle,
    StRdReq,
    StRdWait,
    StWrReq,
    StFin
  } copy_state_e;

endpackage

// File: rtl/ladybird_bus.sv
// ladybird_bus: single-outstanding request/grant bus with a shared tri-state data line.
interface ladybird_bus;
  import ladybird_config::*;

  logic              req;
  logic              gnt;
  logic [XLEN-1:0]   addr;
  logic [XLEN/8-1:0] wstrb;
  wire  [XLEN-1:0]   data;
  logic              data_gnt;

  modport primary (output req, addr, wstrb, input gnt, data_gnt, inout data);
  modport secondary (input req, addr, wstrb, output gnt, data_gnt, inout data);

endinterface

// File: rtl/ladybird_bus_watchdog.sv
// Counts enabled cycles since the last clear; expired flags the final permitted wait cycle.
module ladybird_bus_watchdog #(
  parameter int unsigned TIMEOUT = 64
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int unsigned CntW = $clog2(TIMEOUT + 1);

  logic [CntW-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt_q <= '0;
    end else if (en && !expired) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign expired = en && (cnt_q >= CntW'(TIMEOUT - 1));

endmodule

// File: rtl/ladybird_bus_copy_engine.sv
// Word-by-word memory copy initiator on ladybird_bus: one read, then one full-word write,
// never more than one transaction outstanding.
module ladybird_bus_copy_engine
  import ladybird_config::*;
#(
  parameter int unsigned LEN_W   = 16,
  parameter int unsigned TIMEOUT = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [XLEN-1:0]  src_addr,
  input  logic [XLEN-1:0]  dst_addr,
  input  logic [LEN_W-1:0] len,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [LEN_W-1:0] words_done,
  ladybird_bus.primary     bus
);

  copy_state_e       state_q;
  logic [XLEN-1:0]   src_q, dst_q, buf_q, addr_q;
  logic [LEN_W-1:0]  len_q, words_q, words_inc;
  logic [XLEN-1:0]   src_inc, dst_inc;
  logic [XLEN/8-1:0] wstrb_q;
  logic              req_q, busy_q, done_q, err_q;
  logic              expired;

  always_comb begin
    words_inc = words_q + 1'b1;
    src_inc   = src_q + XLEN'(WORD_BYTES);
    dst_inc   = dst_q + XLEN'(WORD_BYTES);
  end

  ladybird_bus_watchdog #(
    .TIMEOUT (TIMEOUT)
  ) u_watchdog (
    .clk     (clk),
    .rst     (rst),
    .clr     ((state_q == StRdReq) && bus.gnt),
    .en      (state_q == StRdWait),
    .expired (expired)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      req_q   <= 1'b0;
      addr_q  <= '0;
      wstrb_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      words_q <= '0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (start) begin
            src_q   <= src_addr;
            dst_q   <= dst_addr;
            len_q   <= len;
            err_q   <= 1'b0;
            words_q <= '0;
            if (len == '0) begin
              state_q <= StFin;
              done_q  <= 1'b1;
            end else begin
              state_q <= StRdReq;
              busy_q  <= 1'b1;
              req_q   <= 1'b1;
              wstrb_q <= '0;
              addr_q  <= src_addr;
            end
          end
        end
        StRdReq: begin
          if (bus.gnt) begin
            state_q <= StRdWait;
            req_q   <= 1'b0;
          end
        end
        StRdWait: begin
          // A response in the last permitted cycle still wins over the timeout.
          if (bus.data_gnt) begin
            buf_q   <= bus.data;
            state_q <= StWrReq;
            req_q   <= 1'b1;
            wstrb_q <= '1;
            addr_q  <= dst_q;
          end else if (expired) begin
            err_q   <= 1'b1;
            state_q <= StFin;
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
          end
        end
        StWrReq: begin
          if (bus.gnt) begin
            words_q <= words_inc;
            src_q   <= src_inc;
            dst_q   <= dst_inc;
            wstrb_q <= '0;
            if (words_inc == len_q) begin
              state_q <= StFin;
              req_q   <= 1'b0;
              done_q  <= 1'b1;
              busy_q  <= 1'b0;
            end else begin
              state_q <= StRdReq;
              addr_q  <= src_inc;
            end
          end
        end
        StFin: state_q <= StIdle;
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.req    = req_q;
  assign bus.addr   = addr_q;
  assign bus.wstrb  = wstrb_q;
  // Drive the shared data line only while our write is on the bus.
  assign bus.data   = (state_q == StWrReq) ? buf_q : 'z;

  assign busy       = busy_q;
  assign done       = done_q;
  assign err        = err_q;
  assign words_done = words_q;

endmodule
